// File: rtl/textterm_pkg.sv
// Shared constants and types for the textterm character grid and terminal write engine.
package textterm_pkg;

    localparam logic [7:0] CH_CR         = 8'h0D;
    localparam logic [7:0] CH_LF         = 8'h0A;
    localparam logic [7:0] CH_BS         = 8'h08;
    localparam logic [7:0] CH_FF         = 8'h0C;
    localparam logic [7:0] BLANK_DEFAULT = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR_ROW,
        CLEAR_ALL
    } state_e;

endpackage

// File: rtl/textterm_xdiv.sv
// Read-path stage 1: splits the pixel column into character column and glyph sub-column
// using a comparator chain instead of a divider.
module textterm_xdiv
    import textterm_pkg::*;
#(
    parameter int GLYPH_W  = 6,
    parameter int X_BITS   = 8,
    parameter int COL_BITS = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [X_BITS-1:0]   lcd_x,
    output logic [COL_BITS-1:0] col,
    output logic                col_oor,
    output logic [2:0]          sub
);

    localparam int MAXC = ((2 ** X_BITS) - 1) / GLYPH_W;

    int                  col_i;
    logic [COL_BITS-1:0] col_d, col_q;
    logic                oor_d, oor_q;
    logic [2:0]          sub_d, sub_q;

    always_comb begin
        col_i = 0;
        for (int k = 1; k <= MAXC; k++) begin
            if (int'(lcd_x) >= k * GLYPH_W) col_i = k;
        end
        sub_d = 3'(int'(lcd_x) - col_i * GLYPH_W);
        col_d = COL_BITS'(col_i);
        // columns beyond the storage stride would alias after truncation
        oor_d = (col_i >= (2 ** COL_BITS));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q <= '0;
            oor_q <= 1'b0;
            sub_q <= '0;
        end else begin
            col_q <= col_d;
            oor_q <= oor_d;
            sub_q <= sub_d;
        end
    end

    assign col     = col_q;
    assign col_oor = oor_q;
    assign sub     = sub_q;

endmodule

// File: rtl/textterm.sv
// COLS x ROWS text buffer with 2-cycle LCD scan read, terminal-style stream writer,
// hardware scroll through a rotating top-row pointer, and a direct absolute write port.
//
// state     | meaning
// IDLE      | accepting stream characters and direct writes
// CLEAR_ROW | blanking the new bottom row after a scroll
// CLEAR_ALL | blanking every cell, then homing cursor and top pointer
module textterm
    import textterm_pkg::*;
#(
    parameter int         COLS     = 40,
    parameter int         ROWS     = 8,
    parameter int         COL_BITS = 6,
    parameter int         ROW_BITS = 3,
    parameter int         GLYPH_W  = 6,
    parameter int         X_BITS   = 8,
    parameter logic [7:0] BLANK    = BLANK_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [X_BITS-1:0]   lcd_x,
    input  logic [ROW_BITS-1:0] lcd_y,
    output logic [7:0]          char,
    output logic [2:0]          subcol,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    input  logic                wr_strobe,
    input  logic [COL_BITS-1:0] wr_x,
    input  logic [ROW_BITS-1:0] wr_y,
    input  logic [7:0]          wr_data,
    output logic [COL_BITS-1:0] cursor_x,
    output logic [ROW_BITS-1:0] cursor_y,
    output logic                busy
);

    localparam int                  AW       = ROW_BITS + COL_BITS;
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

    logic [7:0] mem [0:(2**AW)-1];

    logic [COL_BITS-1:0] col_s1;
    logic                oor_s1;
    logic [2:0]          sub_s1;
    logic [ROW_BITS-1:0] phys_d, phys_q;
    logic [7:0]          char_d, char_q;
    logic [2:0]          subcol_d, subcol_q;

    state_e              state_d, state_q;
    logic [COL_BITS-1:0] clr_col_d, clr_col_q;
    logic [ROW_BITS-1:0] clr_row_d, clr_row_q;
    logic [COL_BITS-1:0] cur_x_d, cur_x_q;
    logic [ROW_BITS-1:0] cur_y_d, cur_y_q;
    logic [ROW_BITS-1:0] top_d, top_q;

    logic                we;
    logic [AW-1:0]       waddr;
    logic [7:0]          wdata;
    logic                ready_c;
    logic                do_nl;
    logic [ROW_BITS-1:0] wr_row, cur_row, bot_row;

    textterm_xdiv #(
        .GLYPH_W  (GLYPH_W),
        .X_BITS   (X_BITS),
        .COL_BITS (COL_BITS)
    ) u_xdiv (
        .clk     (clk),
        .reset_n (reset_n),
        .lcd_x   (lcd_x),
        .col     (col_s1),
        .col_oor (oor_s1),
        .sub     (sub_s1)
    );

    always_comb begin
        phys_d   = lcd_y + top_q;
        subcol_d = sub_s1;
        // mem read sees pre-write contents on a same-cycle write
        if (oor_s1 || int'(col_s1) >= COLS) char_d = BLANK;
        else                                char_d = mem[{phys_q, col_s1}];
    end

    always_comb begin
        wr_row  = wr_y + top_q;
        cur_row = cur_y_q + top_q;
        bot_row = top_q - ROW_BITS'(1);
    end

    always_comb begin
        state_d   = state_q;
        clr_col_d = clr_col_q;
        clr_row_d = clr_row_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        top_d     = top_q;
        we        = 1'b0;
        waddr     = '0;
        wdata     = BLANK;
        ready_c   = 1'b0;
        do_nl     = 1'b0;

        if (wr_strobe && int'(wr_x) < COLS) begin
            we    = 1'b1;
            waddr = {wr_row, wr_x};
            wdata = wr_data;
        end

        case (state_q)
            IDLE: begin
                ready_c = !wr_strobe;
                if (in_valid && !wr_strobe) begin
                    case (in_data)
                        CH_CR: cur_x_d = '0;
                        CH_LF: do_nl = 1'b1;
                        CH_BS: if (cur_x_q != '0) cur_x_d = cur_x_q - COL_BITS'(1);
                        CH_FF: begin
                            state_d   = CLEAR_ALL;
                            clr_col_d = '0;
                            clr_row_d = '0;
                        end
                        default: begin
                            we    = 1'b1;
                            waddr = {cur_row, cur_x_q};
                            wdata = in_data;
                            if (cur_x_q == LAST_COL) begin
                                cur_x_d = '0;
                                do_nl   = 1'b1;
                            end else begin
                                cur_x_d = cur_x_q + COL_BITS'(1);
                            end
                        end
                    endcase
                end
            end
            CLEAR_ROW: begin
                if (!wr_strobe) begin
                    we    = 1'b1;
                    waddr = {bot_row, clr_col_q};
                    if (clr_col_q == LAST_COL) begin
                        clr_col_d = '0;
                        state_d   = IDLE;
                    end else begin
                        clr_col_d = clr_col_q + COL_BITS'(1);
                    end
                end
            end
            CLEAR_ALL: begin
                if (!wr_strobe) begin
                    we    = 1'b1;
                    waddr = {clr_row_q, clr_col_q};
                    if (clr_col_q == LAST_COL) begin
                        clr_col_d = '0;
                        if (clr_row_q == LAST_ROW) begin
                            clr_row_d = '0;
                            cur_x_d   = '0;
                            cur_y_d   = '0;
                            top_d     = '0;
                            state_d   = IDLE;
                        end else begin
                            clr_row_d = clr_row_q + ROW_BITS'(1);
                        end
                    end else begin
                        clr_col_d = clr_col_q + COL_BITS'(1);
                    end
                end
            end
            default: state_d = CLEAR_ALL;
        endcase

        // scrolling at the bottom: new bottom is the old top row
        if (do_nl) begin
            if (cur_y_q != LAST_ROW) begin
                cur_y_d = cur_y_q + ROW_BITS'(1);
            end else begin
                top_d     = top_q + ROW_BITS'(1);
                clr_col_d = '0;
                state_d   = CLEAR_ROW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phys_q    <= '0;
            char_q    <= BLANK;
            subcol_q  <= '0;
            state_q   <= CLEAR_ALL;
            clr_col_q <= '0;
            clr_row_q <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            top_q     <= '0;
        end else begin
            phys_q    <= phys_d;
            char_q    <= char_d;
            subcol_q  <= subcol_d;
            state_q   <= state_d;
            clr_col_q <= clr_col_d;
            clr_row_q <= clr_row_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            top_q     <= top_d;
        end
    end

    assign char     = char_q;
    assign subcol   = subcol_q;
    assign in_ready = ready_c;
    assign cursor_x = cur_x_q;
    assign cursor_y = cur_y_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_textterm.sv
// Randomized self-checking bench for textterm against a screen-level terminal model.
module tb_textterm;
    import textterm_pkg::*;

    localparam int COLS = 40;
    localparam int ROWS = 8;
    localparam int CB   = 6;
    localparam int RB   = 3;
    localparam int GW   = 6;
    localparam int XB   = 8;
    localparam logic [7:0] BL = 8'h20;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [XB-1:0] lcd_x;
    logic [RB-1:0] lcd_y;
    logic [7:0]    char;
    logic [2:0]    subcol;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          wr_strobe;
    logic [CB-1:0] wr_x;
    logic [RB-1:0] wr_y;
    logic [7:0]    wr_data;
    logic [CB-1:0] cursor_x;
    logic [RB-1:0] cursor_y;
    logic          busy;

    always #5 clk = ~clk;

    textterm dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .lcd_x     (lcd_x),
        .lcd_y     (lcd_y),
        .char      (char),
        .subcol    (subcol),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_strobe (wr_strobe),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_data   (wr_data),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .busy      (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // model: physical screen rows, scroll pointer, cursor
    logic [7:0] scr [ROWS][COLS];
    int top_m, cx_m, cy_m;

    function automatic void m_clear_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = BL;
        top_m = 0; cx_m = 0; cy_m = 0;
    endfunction

    function automatic int m_newline();
        if (cy_m < ROWS - 1) begin
            cy_m++;
            return 0;
        end
        top_m = (top_m + 1) % ROWS;
        for (int c = 0; c < COLS; c++) scr[(top_m + ROWS - 1) % ROWS][c] = BL;
        return COLS;
    endfunction

    // returns the number of clear cycles the character triggers
    function automatic int m_stream(logic [7:0] c);
        if (c == 8'h0D) begin cx_m = 0; return 0; end
        if (c == 8'h0A) return m_newline();
        if (c == 8'h08) begin if (cx_m > 0) cx_m--; return 0; end
        if (c == 8'h0C) begin m_clear_all(); return ROWS * COLS; end
        scr[(cy_m + top_m) % ROWS][cx_m] = c;
        cx_m++;
        if (cx_m == COLS) begin
            cx_m = 0;
            return m_newline();
        end
        return 0;
    endfunction

    function automatic void m_direct(int x, int y, logic [7:0] d);
        if (x < COLS) scr[(y + top_m) % ROWS][x] = d;
    endfunction

    function automatic logic [7:0] m_read(int x, int y);
        int col;
        col = x / GW;
        if (col >= COLS) return BL;
        return scr[(y + top_m) % ROWS][col];
    endfunction

    task automatic check_cursor(string name);
        n_vec++;
        if (int'(cursor_x) !== cx_m || int'(cursor_y) !== cy_m) begin
            n_err++;
            $display("FAIL %s cursor: got (%0d,%0d) want (%0d,%0d)", name, cursor_x, cursor_y, cx_m, cy_m);
        end
    endtask

    // starts at a negedge while busy should be high; counts edges until busy drops
    task automatic wait_busy(int expc, string name);
        int n = 0;
        while (busy && n < 2000) begin
            @(posedge clk); n++;
            @(negedge clk);
        end
        n_vec++;
        if (n !== expc) begin
            n_err++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, n, expc);
        end
    endtask

    task automatic send(logic [7:0] c, string name);
        int k = 0;
        int expc;
        @(negedge clk);
        in_valid = 1'b1; in_data = c;
        #1;
        while (!in_ready && k < 2000) begin
            @(negedge clk); #1; k++;
        end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL %s ready_timeout: got 0 want 1", name);
            @(negedge clk); in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        expc = m_stream(c);
        @(negedge clk);
        in_valid = 1'b0;
        if (expc > 0) wait_busy(expc, name);
    endtask

    task automatic dwrite(int x, int y, logic [7:0] d);
        @(negedge clk);
        wr_strobe = 1'b1; wr_x = CB'(x); wr_y = RB'(y); wr_data = d;
        @(posedge clk);
        m_direct(x, y, d);
        @(negedge clk);
        wr_strobe = 1'b0;
    endtask

    // streams one lcd_x per cycle; each result must appear exactly two edges later
    task automatic scan(int y, int x0, int x1, string name);
        logic [7:0] ec [$];
        logic [2:0] es [$];
        logic [7:0] e8;
        logic [2:0] e3;
        int n = x1 - x0 + 1;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e8 = ec.pop_front();
                e3 = es.pop_front();
                n_vec++;
                if (char !== e8 || subcol !== e3) begin
                    n_err++;
                    $display("FAIL %s scan y=%0d x=%0d: got %h/%0d want %h/%0d",
                             name, y, x0 + i - 2, char, subcol, e8, e3);
                end
            end
            if (i < n) begin
                lcd_x = XB'(x0 + i);
                lcd_y = RB'(y);
                ec.push_back(m_read(x0 + i, y));
                es.push_back(3'((x0 + i) % GW));
            end
        end
    endtask

    task automatic scan_all(string name);
        for (int y = 0; y < ROWS; y++) scan(y, 0, 255, name);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #23;
        n_vec++;
        if (char !== BL || subcol !== 3'd0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_outputs: got char=%h sub=%0d rdy=%b busy=%b want 20/0/0/1",
                     char, subcol, in_ready, busy);
        end
        m_clear_all();
        check_cursor("reset");
        @(negedge clk);
        reset_n = 1'b1;
        wait_busy(ROWS * COLS, "reset_clear");
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
        scan(0, 0, 255, "reset");
    endtask

    task automatic test_reset_midclear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) dwrite(c, r, 8'h41);
        scan(3, 0, 255, "preload");
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        repeat (100) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        wait_busy(ROWS * COLS, "midclear_reset");
        m_clear_all();
        check_cursor("midclear_reset");
        scan_all("midclear_reset");
    endtask

    task automatic test_ab();
        send(8'h41, "ab");
        send(8'h42, "ab");
        scan(0, 0, 11, "ab");
        n_vec++;
        if (cursor_x !== CB'(2) || cursor_y !== RB'(0)) begin
            n_err++;
            $display("FAIL ab cursor: got (%0d,%0d) want (2,0)", cursor_x, cursor_y);
        end
    endtask

    task automatic test_wrap();
        send(CH_FF, "wrap_ff");
        check_cursor("wrap_ff");
        for (int i = 0; i < COLS + 1; i++) send(8'h41 + 8'(i % 26), "wrap");
        n_vec++;
        if (cursor_x !== CB'(1) || cursor_y !== RB'(1)) begin
            n_err++;
            $display("FAIL wrap cursor: got (%0d,%0d) want (1,1)", cursor_x, cursor_y);
        end
        scan(0, 0, 255, "wrap");
        scan(1, 0, 255, "wrap");
    endtask

    task automatic test_scroll();
        dwrite(5, 7, 8'h51);
        while (cy_m < ROWS - 1) send(CH_LF, "scroll_lf");
        send(CH_LF, "scroll");
        check_cursor("scroll");
        scan(0, 0, 255, "scroll_row0");
        scan(7, 0, 255, "scroll_row7");
    endtask

    task automatic test_collide();
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h5A;
        wr_strobe = 1'b1; wr_x = CB'(3); wr_y = RB'(2); wr_data = 8'h57;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL collide ready_during_wr: got %b want 0", in_ready);
        end
        @(posedge clk);
        m_direct(3, 2, 8'h57);
        @(negedge clk);
        wr_strobe = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL collide ready_after_wr: got %b want 1", in_ready);
        end
        @(posedge clk);
        void'(m_stream(8'h5A));
        @(negedge clk);
        in_valid = 1'b0;
        check_cursor("collide");
        scan(2, 0, 40, "collide");
        scan(7, 0, 255, "collide");
    endtask

    task automatic test_clear_row_stall();
        int n = 0;
        int expc;
        @(negedge clk);
        in_valid = 1'b1; in_data = CH_LF;
        @(posedge clk);
        expc = m_stream(CH_LF);
        @(negedge clk);
        in_valid = 1'b0;
        wr_strobe = 1'b1; wr_x = CB'(7); wr_y = RB'(0); wr_data = 8'h53;
        while (busy && n < 2000) begin
            @(posedge clk);
            if (n == 0) m_direct(7, 0, 8'h53);
            n++;
            @(negedge clk);
            wr_strobe = 1'b0;
        end
        n_vec++;
        if (n !== expc + 1) begin
            n_err++;
            $display("FAIL clear_row_stall busy_cycles: got %0d want %0d", n, expc + 1);
        end
        scan_all("clear_row_stall");
    endtask

    task automatic test_backspace();
        send(CH_CR, "bs_cr");
        send(CH_BS, "bs_at0");
        n_vec++;
        if (cursor_x !== CB'(0)) begin
            n_err++;
            $display("FAIL bs_at0 cursor_x: got %0d want 0", cursor_x);
        end
        check_cursor("bs_at0");
        send(8'h61, "bs");
        send(8'h62, "bs");
        send(CH_BS, "bs");
        check_cursor("bs_dec");
        send(8'h63, "bs");
        scan(cy_m, 0, 30, "bs");
    endtask

    task automatic test_ff();
        send(8'h31, "ff");
        send(8'h32, "ff");
        send(CH_FF, "ff");
        n_vec++;
        if (cursor_x !== CB'(0) || cursor_y !== RB'(0)) begin
            n_err++;
            $display("FAIL ff cursor: got (%0d,%0d) want (0,0)", cursor_x, cursor_y);
        end
        dwrite(0, 0, 8'h5E);
        scan_all("ff");
    endtask

    task automatic test_random();
        int sel;
        for (int it = 0; it < 600; it++) begin
            sel = $urandom_range(0, 99);
            if (sel < 70)      send(8'($urandom_range(8'h21, 8'h7E)), "rand_char");
            else if (sel < 78) send(CH_CR, "rand_cr");
            else if (sel < 88) send(CH_LF, "rand_lf");
            else if (sel < 93) send(CH_BS, "rand_bs");
            else dwrite($urandom_range(0, 63), $urandom_range(0, ROWS - 1),
                        8'($urandom_range(8'h21, 8'h7E)));
            check_cursor("rand");
            if (it == 300) scan_all("rand_mid");
        end
        scan_all("rand_end");
    endtask

    initial begin
        reset_n = 1'b0; lcd_x = '0; lcd_y = '0;
        in_valid = 1'b0; in_data = '0;
        wr_strobe = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
        test_reset();
        test_reset_midclear();
        test_ab();
        test_wrap();
        test_scroll();
        test_collide();
        test_clear_row_stall();
        test_backspace();
        test_ff();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
